// File: rtl/parking_pkg.sv
// Shared types and beam patterns for the parking sensor emitter and its matching detector.
// Patterns are packed as {sensor_a, sensor_b}.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    PH3  = 2'd3
  } state_e;

  typedef enum logic {
    ENTER = 1'b0,
    EXIT  = 1'b1
  } dir_e;

  localparam logic [1:0] PAT_CLEAR = 2'b00;
  localparam logic [1:0] PAT_A     = 2'b10;
  localparam logic [1:0] PAT_AB    = 2'b11;
  localparam logic [1:0] PAT_B     = 2'b01;

  // An exit is the entry sequence with the roles of the two beams swapped.
  function automatic logic [1:0] phase_pattern(input dir_e dir, input state_e st);
    logic [1:0] pat;
    pat = PAT_CLEAR;
    case (st)
      PH1:     pat = (dir == ENTER) ? PAT_A : PAT_B;
      PH2:     pat = PAT_AB;
      PH3:     pat = (dir == ENTER) ? PAT_B : PAT_A;
      default: pat = PAT_CLEAR;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/parking_sensor_emitter_dwell_timer.sv
// Loadable down-counter that times one sensor phase.
// expire is high in the last of the DWELL cycles that follow a load.
module dwell_timer
  import parking_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = RELOAD;
    end else if (count && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == 8'd0);

endmodule

// File: rtl/parking_sensor_emitter.sv
// Emits the two-beam pattern of a car entering or leaving, for driving a detector under test.
// Optional occupancy counter enabled by defining PSE_OCCUPANCY_EN.
module parking_sensor_emitter
  import parking_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int CAPACITY = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_enter,
  input  logic       start_exit,
  output logic       sensor_a,
  output logic       sensor_b,
  output logic       busy,
  output logic       done
`ifdef PSE_OCCUPANCY_EN
  ,
  output logic [3:0] occupancy
`endif
);

  if (CAPACITY < 0 || CAPACITY > 15) begin : g_capacity_check
    $error("CAPACITY must fit the 4-bit occupancy count");
  end

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [1:0] pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic timer_load;
  logic timer_count;
  logic timer_expire;

`ifdef PSE_OCCUPANCY_EN
  localparam logic [3:0] CAP = 4'(CAPACITY);

  logic [3:0] occ_q, occ_d;
`endif

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .count   (timer_count),
    .expire  (timer_expire)
  );

  // Outputs are computed for the next state so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    pat_d       = pat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timer_load  = 1'b0;
    timer_count = 1'b0;
`ifdef PSE_OCCUPANCY_EN
    occ_d       = occ_q;
`endif

    case (state_q)
      IDLE: begin
        pat_d  = PAT_CLEAR;
        busy_d = 1'b0;
        if (start_enter || start_exit) begin
          dir_d      = start_enter ? ENTER : EXIT;
          state_d    = PH1;
          pat_d      = phase_pattern(dir_d, PH1);
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end

      PH1: begin
        if (timer_expire) begin
          state_d    = PH2;
          pat_d      = phase_pattern(dir_q, PH2);
          timer_load = 1'b1;
        end else begin
          timer_count = 1'b1;
        end
      end

      PH2: begin
        if (timer_expire) begin
          state_d    = PH3;
          pat_d      = phase_pattern(dir_q, PH3);
          timer_load = 1'b1;
        end else begin
          timer_count = 1'b1;
        end
      end

      PH3: begin
        if (timer_expire) begin
          state_d = IDLE;
          pat_d   = PAT_CLEAR;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef PSE_OCCUPANCY_EN
          if (dir_q == ENTER) begin
            if (occ_q < CAP) occ_d = occ_q + 4'd1;
          end else begin
            if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
          end
`endif
        end else begin
          timer_count = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        pat_d   = PAT_CLEAR;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q   <= ENTER;
      pat_q   <= PAT_CLEAR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PSE_OCCUPANCY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ_q <= 4'd0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

  assign sensor_a = pat_q[1];
  assign sensor_b = pat_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_parking_sensor_emitter.sv
// Directed bench for parking_sensor_emitter with DWELL=4; occupancy checks compile in
// only when PSE_OCCUPANCY_EN is defined.
module tb_parking_sensor_emitter;

  localparam int DWELL = 4;

  logic clk;
  logic reset_n;
  logic start_enter;
  logic start_exit;
  logic sensor_a;
  logic sensor_b;
  logic busy;
  logic done;
`ifdef PSE_OCCUPANCY_EN
  logic [3:0] occupancy;
`endif

  int checks;
  int failures;

  parking_sensor_emitter #(
    .DWELL    (DWELL),
    .CAPACITY (15)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_enter (start_enter),
    .start_exit  (start_exit),
    .sensor_a    (sensor_a),
    .sensor_b    (sensor_b),
    .busy        (busy),
    .done        (done)
`ifdef PSE_OCCUPANCY_EN
    ,
    .occupancy   (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge, where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected value is {sensor_a, sensor_b, busy, done}.
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {sensor_a, sensor_b, busy, done};
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

`ifdef PSE_OCCUPANCY_EN
  task automatic checkOcc(input string tag, input logic [3:0] expected);
    checks++;
    assert (occupancy === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, occupancy, expected);
    end
  endtask
`endif

  // Entered at t1 of a sequence; checks t1..t12 and ends sampled in the done cycle.
  // pokeCycle pulses start_exit during that cycle to show it is ignored while busy.
  task automatic applyStimulus(input bit isEntry, input int pokeCycle, input string tag);
    logic [3:0] expected;
    int phase;
    for (int i = 1; i <= 3 * DWELL; i++) begin
      phase = (i - 1) / DWELL;
      case (phase)
        0:       expected = isEntry ? 4'b1010 : 4'b0110;
        1:       expected = 4'b1110;
        default: expected = isEntry ? 4'b0110 : 4'b1010;
      endcase
      checkOutput($sformatf("%s_t%0d", tag, i), expected);
      if (i == pokeCycle) start_exit = 1'b1;
      tick();
      start_exit = 1'b0;
    end
    checkOutput($sformatf("%s_done", tag), 4'b0001);
  endtask

  task automatic quickSequence(input bit isEntry);
    start_enter = isEntry;
    start_exit  = !isEntry;
    tick();
    start_enter = 1'b0;
    start_exit  = 1'b0;
    repeat (3 * DWELL) tick();
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    start_enter = 1'b0;
    start_exit  = 1'b0;

    tick();
    checkOutput("reset_state", 4'b0000);
`ifdef PSE_OCCUPANCY_EN
    checkOcc("reset_occ", 4'd0);
`endif

    start_enter = 1'b1;
    tick();
    checkOutput("start_during_reset", 4'b0000);
    reset_n     = 1'b1;
    start_enter = 1'b0;
    tick();
    checkOutput("idle_after_reset", 4'b0000);

    start_enter = 1'b1;
    tick();
    start_enter = 1'b0;
    checkOutput("abort_ph1", 4'b1010);
    repeat (DWELL) tick();
    checkOutput("abort_ph2", 4'b1110);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("abort_cleared", 4'b0000);
    for (int i = 0; i < 3 * DWELL; i++) begin
      tick();
      checkOutput($sformatf("abort_quiet_%0d", i), 4'b0000);
    end
`ifdef PSE_OCCUPANCY_EN
    checkOcc("abort_occ", 4'd0);
`endif

    start_enter = 1'b1;
    tick();
    start_enter = 1'b0;
    applyStimulus(1'b1, 0, "entry");
`ifdef PSE_OCCUPANCY_EN
    checkOcc("entry_occ", 4'd1);
`endif
    tick();
    checkOutput("entry_idle", 4'b0000);

    start_exit = 1'b1;
    tick();
    start_exit = 1'b0;
    applyStimulus(1'b0, 0, "b2b_exit");
`ifdef PSE_OCCUPANCY_EN
    checkOcc("b2b_exit_occ", 4'd0);
`endif
    start_enter = 1'b1;
    tick();
    start_enter = 1'b0;
    applyStimulus(1'b1, 0, "b2b_entry");
    tick();
    checkOutput("b2b_idle", 4'b0000);

    start_enter = 1'b1;
    tick();
    start_enter = 1'b0;
    applyStimulus(1'b1, DWELL + 2, "busy_poke");
    tick();
    checkOutput("busy_poke_idle0", 4'b0000);
    tick();
    checkOutput("busy_poke_idle1", 4'b0000);

    start_enter = 1'b1;
    start_exit  = 1'b1;
    tick();
    start_enter = 1'b0;
    start_exit  = 1'b0;
    applyStimulus(1'b1, 0, "both");
    tick();
    checkOutput("both_idle", 4'b0000);
`ifdef PSE_OCCUPANCY_EN
    checkOcc("both_occ", 4'd3);

    repeat (16) quickSequence(1'b1);
    checkOcc("sat_high", 4'd15);
    quickSequence(1'b0);
    checkOcc("one_exit", 4'd14);
    repeat (16) quickSequence(1'b0);
    checkOcc("sat_low", 4'd0);
`else
    quickSequence(1'b0);
    checkOutput("quick_idle", 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
